// File: rtl/ex_muldiv.sv
// ----------------------------------------------------------------------------
// ex_muldiv : iterative RV32M multiply/divide unit for the execute stage.
//
// Sits right after the ID/EX register. An M-extension instruction
// (OP opcode, funct7 = 0000001) is accepted while idle. The unit then runs
// 32 shift-add multiply steps or 32 restoring-divide steps, one per cycle,
// on operand magnitudes. The sign correction is applied as the result
// register is loaded on entry to DONE. Divide-by-zero and signed overflow
// skip the iterations and go straight to DONE. busy_o stalls upstream for
// the whole operation.
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous reset, active HIGH (historic name)
//   valid_i      ID/EX holds a valid instruction
//   opcode_i     opcode        funct3_i  funct3       funct7_i  funct7
//   rd_i         destination register
//   rs1_data_i   rs1 operand   rs2_data_i  rs2 operand
//   flush_i      kill in-flight operation (no effect in DONE)
//   busy_o       unit occupied (registered, low in the accept cycle)
//   done_o       one-cycle result-valid pulse
//   wr_en_o      done_o && rd_o != 0
//   rd_o         destination register of the completed op
//   result_o     result, valid while done_o = 1
// ----------------------------------------------------------------------------
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            wr_en_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [6:0]      OPC_OP   = 7'b0110011;
    localparam logic [6:0]      F7_MULDV = 7'b0000001;
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         op_q;
    logic [4:0]         rd_q;
    logic               neg_q;
    // Multiplicand (MUL) or divisor (DIV) magnitude.
    logic [XLEN-1:0]    mcand_q;
    // MUL: {partial product high, multiplier / product low}.
    // DIV: {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*XLEN-1:0]  acc_q;
    logic               busy_q;
    logic               done_q;
    logic               wr_en_q;
    logic [4:0]         rd_out_q;
    logic [XLEN-1:0]    result_q;

    // ------------------------------------------------------------------
    // Accept decode and operand preparation
    // ------------------------------------------------------------------
    logic               accept;
    logic               signed1;
    logic               signed2;
    logic               neg1;
    logic               neg2;
    logic [XLEN-1:0]    mag1;
    logic [XLEN-1:0]    mag2;
    logic               neg_d;
    logic               div_zero;
    logic               div_ovf;
    logic               special;
    logic [XLEN-1:0]    special_res;

    always_comb begin
        accept  = (state_q == S_IDLE) && valid_i && (opcode_i == OPC_OP)
                  && (funct7_i == F7_MULDV) && !flush_i;

        // MULHU, DIVU and REMU treat rs1 as unsigned; MULHSU also rs2.
        signed1 = (funct3_i != 3'd3) && (funct3_i != 3'd5) && (funct3_i != 3'd7);
        signed2 = signed1 && (funct3_i != 3'd2);
        neg1    = signed1 & rs1_data_i[XLEN-1];
        neg2    = signed2 & rs2_data_i[XLEN-1];
        mag1    = neg1 ? (XLEN'(0) - rs1_data_i) : rs1_data_i;
        mag2    = neg2 ? (XLEN'(0) - rs2_data_i) : rs2_data_i;
        // Remainder takes the dividend's sign; everything else the XOR.
        neg_d   = (funct3_i[2] & funct3_i[1]) ? neg1 : (neg1 ^ neg2);

        div_zero = (rs2_data_i == '0);
        // Signed overflow only exists for DIV/REM (funct3[0] = 0).
        div_ovf  = !funct3_i[0] && (rs1_data_i == INT_MIN) && (rs2_data_i == '1);
        special  = funct3_i[2] & (div_zero | div_ovf);

        if (div_zero) begin
            special_res = funct3_i[1] ? rs1_data_i : '1;
        end else begin
            special_res = funct3_i[1] ? '0 : INT_MIN;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath and final sign fix-up
    // ------------------------------------------------------------------
    logic [XLEN:0]      mul_sum;
    logic [2*XLEN-1:0]  mul_next;
    logic [XLEN:0]      div_shift;
    logic               div_ge;
    logic [XLEN-1:0]    div_diff;
    logic [2*XLEN-1:0]  div_next;
    logic [2*XLEN-1:0]  step_next;
    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    quo_fix;
    logic [XLEN-1:0]    rem_fix;
    logic [XLEN-1:0]    final_res;

    always_comb begin
        // Shift-add: add multiplicand into the high half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                   + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring divide: bring in the next dividend bit, subtract the
        // divisor if it fits. The true difference is below the divisor, so
        // its low XLEN bits are exact even when the shifted value overflows.
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, mcand_q});
        div_diff  = div_shift[XLEN-1:0] - mcand_q;
        div_next  = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                           : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

        step_next = (state_q == S_MUL) ? mul_next : div_next;

        prod_fix = neg_q ? ((2*XLEN)'(0) - step_next) : step_next;
        quo_fix  = neg_q ? (XLEN'(0) - step_next[XLEN-1:0]) : step_next[XLEN-1:0];
        rem_fix  = neg_q ? (XLEN'(0) - step_next[2*XLEN-1:XLEN])
                         : step_next[2*XLEN-1:XLEN];

        case (op_q)
            3'd0:          final_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          final_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:    final_res = quo_fix;
            default:       final_res = rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_en_q  <= 1'b0;
            rd_out_q <= '0;
            result_q <= '0;
        end else begin
            // Pulse outputs default low; only the DONE entry raises them.
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= funct3_i;
                        rd_q   <= rd_i;
                        neg_q  <= neg_d;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (special) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            wr_en_q  <= (rd_i != 5'd0);
                            rd_out_q <= rd_i;
                            result_q <= special_res;
                        end else if (funct3_i[2]) begin
                            state_q <= S_DIV;
                            mcand_q <= mag2;
                            acc_q   <= {{XLEN{1'b0}}, mag1};
                        end else begin
                            state_q <= S_MUL;
                            mcand_q <= mag1;
                            acc_q   <= {{XLEN{1'b0}}, mag2};
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= step_next;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            wr_en_q  <= (rd_q != 5'd0);
                            rd_out_q <= rd_q;
                            result_q <= final_res;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign wr_en_o  = wr_en_q;
    assign rd_o     = rd_out_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv : randomized self-checking bench for ex_muldiv.
// A behavioural model (plain 64-bit arithmetic) predicts each op's result
// and completion cycle; a per-cycle compare process checks busy/done/wr_en
// and, on the done cycle, result and rd.
// ----------------------------------------------------------------------------
module tb_ex_muldiv;

    localparam logic [6:0] OPC_OP = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid_i = 1'b0;
    logic [6:0]  opcode_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [6:0]  funct7_i = '0;
    logic [4:0]  rd_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        wr_en_o;
    logic [4:0]  rd_o;
    logic [31:0] result_o;

    ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .opcode_i   (opcode_i),
        .funct3_i   (funct3_i),
        .funct7_i   (funct7_i),
        .rd_i       (rd_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .wr_en_o    (wr_en_o),
        .rd_o       (rd_o),
        .result_o   (result_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Expectation of the single op in flight.
    bit          cmp_en = 1'b0;
    bit          exp_active = 1'b0;
    bit          exp_aborted = 1'b0;
    int          exp_acc = 0;
    int          exp_end = 0;
    logic [31:0] exp_res = '0;
    logic [4:0]  exp_rd = '0;
    logic [31:0] last_res = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the RV32M result from plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Cycles from the accept cycle to the done cycle.
    function automatic int latency(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 1;
        return 33;
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic eb;
            logic ed;
            eb = exp_active && (cyc > exp_acc) && (cyc <= exp_end);
            ed = exp_active && !exp_aborted && (cyc == exp_end);
            chk("busy", 32'(busy_o), 32'(eb));
            chk("done", 32'(done_o), 32'(ed));
            chk("wr_en", 32'(wr_en_o), 32'(ed && (exp_rd != 5'd0)));
            if (ed) begin
                chk("result", result_o, exp_res);
                chk("rd", 32'(rd_o), 32'(exp_rd));
                last_res = result_o;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        valid_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        valid_i    = 1'b1;
        opcode_i   = OPC_OP;
        funct7_i   = 7'b0000001;
        funct3_i   = op;
        rd_i       = rd;
        rs1_data_i = a;
        rs2_data_i = b;
        flush_i    = 1'b0;
        exp_res     = model(op, a, b);
        exp_rd      = rd;
        exp_acc     = cyc;
        exp_end     = cyc + latency(op, a, b);
        exp_aborted = 1'b0;
        exp_active  = 1'b1;
        step();
    endtask

    // Full op; while busy the inputs carry junk that must be ignored,
    // including a possible flush in the DONE cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        issue(op, a, b, rd);
        while (cyc <= exp_end) begin
            valid_i    = 1'($urandom_range(0, 1));
            opcode_i   = ($urandom_range(0, 3) != 0) ? OPC_OP : 7'($urandom);
            funct7_i   = ($urandom_range(0, 1) != 0) ? 7'd1 : 7'd0;
            funct3_i   = 3'($urandom);
            rd_i       = 5'($urandom);
            rs1_data_i = $urandom;
            rs2_data_i = $urandom;
            flush_i    = (cyc == exp_end) ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        drive_idle();
        exp_active = 1'b0;
        $display("op=%0d a=%h b=%h rd=%0d result=%h expected=%h", op, a, b, rd, last_res, exp_res);
    endtask

    // Op killed by flush or reset after 'at' cycles of iteration.
    task automatic run_abort(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input int at, input bit use_reset);
        issue(op, a, b, rd);
        drive_idle();
        while (cyc < exp_acc + at) step();
        if (use_reset) rst_n = 1'b1;
        else flush_i = 1'b1;
        exp_end     = cyc;
        exp_aborted = 1'b1;
        step();
        rst_n   = 1'b0;
        flush_i = 1'b0;
        if (use_reset) begin
            chk("rst_rd", 32'(rd_o), 32'd0);
            chk("rst_result", result_o, 32'd0);
        end
        chk("abort_idle", 32'(busy_o), 32'd0);
        exp_active = 1'b0;
        $display("op=%0d a=%h b=%h rd=%0d aborted by %s after %0d cycles", op, a, b, rd,
                 use_reset ? "reset" : "flush", at);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            4: return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Model pins against hand-computed values.
        chk("model_mul", model(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
        chk("model_mulhsu", model(3'd2, 32'h80000000, 32'h80000000), 32'hC0000000);
        chk("model_div", model(3'd4, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
        chk("model_rem", model(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);

        rst_n = 1'b1;
        step(); step(); step();
        rst_n = 1'b0;
        cmp_en = 1'b1;
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_wr_en", 32'(wr_en_o), 32'd0);
        chk("reset_rd", 32'(rd_o), 32'd0);
        chk("reset_result", result_o, 32'd0);
        step();

        // Directed cases with literal expectations on the DUT result.
        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5);
        chk("lit_mul", last_res, 32'hFFFFFFEB);
        run_op(3'd1, 32'h80000000, 32'h80000000, 5'd1);
        chk("lit_mulh", last_res, 32'h40000000);
        run_op(3'd2, 32'h80000000, 32'h80000000, 5'd2);
        chk("lit_mulhsu", last_res, 32'hC0000000);
        run_op(3'd3, 32'h80000000, 32'h80000000, 5'd3);
        chk("lit_mulhu", last_res, 32'h40000000);
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4);
        chk("lit_div", last_res, 32'hFFFFFFFD);
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd6);
        chk("lit_rem", last_res, 32'hFFFFFFFF);
        run_op(3'd5, 32'd100, 32'd7, 5'd7);
        chk("lit_divu", last_res, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, 5'd8);
        chk("lit_remu", last_res, 32'd2);
        run_op(3'd4, 32'd123, 32'd0, 5'd9);
        chk("lit_div0", last_res, 32'hFFFFFFFF);
        run_op(3'd6, 32'd123, 32'd0, 5'd10);
        chk("lit_rem0", last_res, 32'd123);
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11);
        chk("lit_div_ovf", last_res, 32'h80000000);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12);
        chk("lit_rem_ovf", last_res, 32'd0);
        run_op(3'd0, 32'd3, 32'd4, 5'd0);
        chk("lit_mul_rd0", last_res, 32'd12);

        // Aborts, each followed by a clean op.
        run_abort(3'd4, 32'd1000, 32'd3, 5'd13, 10, 1'b0);
        run_op(3'd5, 32'd1000, 32'd3, 5'd14);
        run_abort(3'd0, 32'h12345678, 32'h9ABCDEF0, 5'd15, 20, 1'b1);
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd16);

        // Non-M instruction and flush+accept must not start the unit.
        valid_i = 1'b1; opcode_i = OPC_OP; funct7_i = 7'd0; funct3_i = 3'd0; rd_i = 5'd3;
        step();
        drive_idle();
        chk("non_m_busy", 32'(busy_o), 32'd0);
        valid_i = 1'b1; opcode_i = OPC_OP; funct7_i = 7'd1; funct3_i = 3'd4; flush_i = 1'b1;
        step();
        drive_idle();
        chk("flush_accept_busy", 32'(busy_o), 32'd0);
        step();

        // Randomized ops, back to back.
        for (int i = 0; i < 250; i++) begin
            run_op(3'($urandom), rnd_opnd(), rnd_opnd(), 5'($urandom));
        end
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It consumes the registered opcode, funct3, funct7, rd and rs1/rs2 register data. It runs a 32-iteration shift-add multiply or restoring divide, and holds the upstream pipeline with busy_o until the result is written back. Non-M instructions are ignored; the ALU path handles them.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration counter width; must hold the value XLEN.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset, synchronous, active-high (asserted = 1); named as in the codebase.
valid_i  input  1  ID/EX outputs hold a valid instruction this cycle.
opcode_i  input  7  opcode from ID/EX.
funct3_i  input  3  funct3 from ID/EX.
funct7_i  input  7  funct7 from ID/EX.
rd_i  input  5  destination register from ID/EX.
rs1_data_i  input  XLEN  rs1 register data from ID/EX.
rs2_data_i  input  XLEN  rs2 register data from ID/EX.
flush_i  input  1  kill the in-flight operation (branch/exception).
busy_o  output  1  unit occupied; upstream must hold ID/EX while high.
done_o  output  1  one-cycle result-valid pulse.
wr_en_o  output  1  regfile write enable; equals done_o and (rd_o != 0).
rd_o  output  5  destination register of the completed op.
result_o  output  XLEN  result, valid only while done_o = 1.

Behaviour:
- Accept condition: state IDLE, valid_i = 1, opcode_i = 7'b0110011, funct7_i = 7'b0000001, flush_i = 0. On the accept edge the unit latches funct3, rd and both operands.
- funct3 mapping: 0 MUL (low word); 1 MULH (s×s, high); 2 MULHSU (s×u, high); 3 MULHU (u×u, high); 4 DIV; 5 DIVU; 6 REM; 7 REMU.
- Operand handling: the unit takes the magnitude of each signed operand and records the result sign. MUL/MULH sign = sign1 XOR sign2. MULHSU treats rs2 as unsigned. DIV quotient sign = sign1 XOR sign2. REM sign = dividend sign. The unit negates the 64-bit product, quotient or remainder in the DONE state when the sign is negative.
- State machine (IDLE, MUL, DIV, DONE):
  - IDLE -> MUL on a multiply accept.
  - IDLE -> DIV on a divide accept.
  - IDLE -> DONE directly on a special-case divide.
  - MUL/DIV -> DONE when the counter reaches XLEN-1; each state performs exactly 32 iterations, one per cycle.
  - DONE -> IDLE unconditionally after one cycle.
- Multiply: shift-add, 64-bit accumulator.
- Divide: restoring divide, one quotient bit per cycle.
- Latency: the accept edge is edge 0. The normal case reaches DONE after edge 32, so done_o is high in the 33rd cycle after the accept cycle. Special cases reach DONE after edge 0, so done_o is high in the next cycle.
- Special cases, resolved in one step:
  - Divide by zero: DIV/DIVU give 32'hFFFFFFFF; REM/REMU give the dividend.
  - Signed overflow (DIV with 32'h80000000 / 32'hFFFFFFFF): quotient 32'h80000000, remainder 0.
- Outputs:
  - busy_o = (state != IDLE), registered. It is not asserted in the accept cycle itself; ID/EX advances normally in that cycle.
  - done_o = (state == DONE). wr_en_o is gated as listed under Ports.
  - result_o and rd_o are held stable for the whole DONE cycle.
- Reset: every state register clears. state = IDLE, counter = 0. busy_o, done_o and wr_en_o = 0. rd_o = 0, result_o = 0. A reset mid-operation aborts the op on the next edge with no done_o.
- Flush:
  - flush_i in MUL or DIV: state -> IDLE next edge, no done_o, accumulators untouched.
  - flush_i in DONE: done_o still completes that cycle; writeback gating is the consumer's job.
  - flush_i and an accept condition in the same cycle: no accept.
- valid_i while busy: ignored; upstream is stalled by busy_o.
- Back-to-back ops: a new op may be accepted in the cycle after DONE (IDLE cycle), not during DONE.

Test Plan:
- MUL rs1 = 7, rs2 = -3 (32'hFFFFFFFD), rd = 5 -> done_o 33 cycles after accept; result_o = 32'hFFFFFFEB, wr_en_o = 1, rd_o = 5; busy_o high for 33 cycles.
- MULH/MULHSU/MULHU with rs1 = rs2 = 32'h80000000 -> 32'h40000000 / 32'hC0000000 / 32'h40000000.
- DIV -7/2 -> 32'hFFFFFFFD; REM -7/2 -> 32'hFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV x/0 with x = 123 -> 32'hFFFFFFFF, REM x/0 -> 123; DIV 32'h80000000 / -1 -> 32'h80000000, REM -> 0; each with done_o 1 cycle after accept.
- Flush at iteration 10 of a DIV -> IDLE next cycle, done_o never asserted. Reset asserted at iteration 20 of a MUL -> all outputs 0 next cycle. Next op accepted cleanly afterwards.
- Non-M instruction (opcode 0110011, funct7 = 0) with valid_i = 1 -> no accept, busy_o = 0. MUL with rd = 0 -> done_o = 1, wr_en_o = 0.
